port_input_responder: RTL and testbench
=======================================

Name: port_input_responder

Overview:
- Responder side of the CPU port bus. The CPU initiates reads with portget/portaddr; this block answers on portout.
- Serves the board switches and buttons as read-only ports:
  - 2-flop synchronisation and sample-based debounce on every input.
  - Sticky button-press event latches, cleared when the CPU reads them.
- Sits in the FPGA top beside the display port writer. Ports BASE_ADDR and BASE_ADDR+1 are decoded here.

Parameters:
- WORD_SIZE, 16: port data/address width; matches the shared parameters.
- BASE_ADDR, 2: first port address served. Ports 0/1 belong to the display writer.
- N_SW, 8: number of switch inputs.
- N_BTN, 4: number of button inputs.
- DEB_DIV_LOG2, 16: debounce sample strobe period is 2^DEB_DIV_LOG2 mclk cycles.
- DEB_SAMPLES, 4: number of consecutive equal samples required to change a debounced level (>=2).

Ports:
- mclk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_tick  in  1  one-mclk pulse marking the CPU clock rising edge. Bus handshakes qualify on it.
- portaddr  in  WORD_SIZE  port address from the CPU.
- portget  in  1  CPU read request.
- portout  out  WORD_SIZE  read data to the CPU.
- port_hit  out  1  high when portget targets a port served here.
- sw_in  in  N_SW  raw asynchronous switches.
- btn_in  in  N_BTN  raw asynchronous buttons.
- sw_level  out  N_SW  debounced switch levels, for local LEDs.

Behaviour:
- Reset (rst_n low, async): clear all of the following.
  - Synchroniser flops, sample histories, debounced levels, event latches, prescaler.
  - Outputs: portout=0, port_hit=0, sw_level=0.
- Reset mid-read: the read is lost and no event bits are cleared.
- Synchroniser: two flops per input bit; the second flop is the sampled value.
- Prescaler:
  - DEB_DIV_LOG2-bit free-running counter.
  - samp_stb is high for one cycle whenever the counter is all-ones; it wraps to 0.
- Debounce, per bit, on samp_stb:
  - Shift the synchronised bit into a DEB_SAMPLES-deep history.
  - If the new history is all ones, the level becomes 1. If all zeros, it becomes 0. Otherwise the level holds.
  - Worst-case latency from a stable input change to a level change: 2 + DEB_SAMPLES*2^DEB_DIV_LOG2 cycles.
- Event latch, per button:
  - The bit is set on the cycle the debounced level goes 0->1 (registered previous level).
- Address decode:
  - hit0 = portget & (portaddr == BASE_ADDR).
  - hit1 = portget & (portaddr == BASE_ADDR+1).
  - port_hit = hit0 | hit1.
- portout is combinational from registers:
  - hit0: {zeros, sw_level}, zero-extended to WORD_SIZE.
  - hit1: bits [N_BTN-1:0] = event latches; bits [2*N_BTN-1:N_BTN] = debounced button levels; upper bits 0.
  - Any other case, including portget low: 0.
- Read-clear:
  - On a cycle with cpu_tick & hit1, event latches clear. Reads without cpu_tick clear nothing.
  - Exactly one clear per CPU read, because cpu_tick is a single pulse.
- Simultaneous set and clear: if a bit's new rising edge coincides with its read-clear cycle, the bit ends set. Set has priority, so no event is lost.
- Reads of BASE_ADDR have no side effects.
- Writes (portset) are ignored. This block has no portset/portval inputs.
- Multiple presses between reads collapse to a single event bit (no count).
- Address wrap: BASE_ADDR+1 is computed modulo 2^WORD_SIZE.

Decomposition:
- Shared parameters file: WORD_SIZE, plus the port address constants:
  - PORT_DISPLAY0 = 0, PORT_DISPLAY1 = 1.
  - PORT_SWITCHES = 2, PORT_BUTTONS = 3.
- Sub-module debounce_bit:
  - Contains the synchroniser, history and level for one input.
  - Inputs: mclk, rst_n, samp_stb, raw. Output: level.
  - Instantiated N_SW+N_BTN times by a generate loop.
- Prescaler, decode, event latches and read mux stay in the top of this block.

Test Plan (bench uses DEB_DIV_LOG2=2, DEB_SAMPLES=4):
1. Reset and idle:
   - Stimulus: hold rst_n low with sw_in=8'hA5 and portget=1 at addr 2.
   - Required: portout=0, port_hit=0, sw_level=0 throughout reset.
   - After release, sw_level=8'hA5 within 2+16 cycles, and addr-2 reads return 16'h00A5.
2. Bounce rejection:
   - Stimulus: toggle btn_in[0] every 3 cycles for 40 cycles, then hold it low.
   - Required: event bit 0 is never set and the level stays 0.
3. Press and read-clear:
   - Stimulus: hold btn_in[2]=1 for 30 cycles; read addr 3 with cpu_tick.
   - Required: the read returns 16'h0044. The next read returns 16'h0040, because the level is still 1 and the event is cleared.
4. Set/clear collision:
   - Stimulus: align a read of addr 3 with cpu_tick to the exact cycle btn 1's debounced level rises.
   - Required: the read returns bit1=0, and the following read returns bit1=1.
5. Decode:
   - Stimulus: portget at addrs 0, 1, 4 and 16'hFFFF.
   - Required: port_hit=0 and portout=0 each time.
   - Stimulus: read addr 3 without cpu_tick.
   - Required: data is returned and the events are not cleared.
6. Async reset mid-operation:
   - Stimulus: assert rst_n low for 1 cycle while events = 4'hF.
   - Required: events read back 0 after reset.

Source files
------------

// File: rtl/port_input_responder_pkg.sv
// Shared port-bus constants for the CPU port responder and its neighbours.
package port_input_responder_pkg;

    // Port bus data/address width shared with the CPU and the display writer.
    localparam int WORD_SIZE = 16;

    // Port address map.
    localparam int PORT_DISPLAY0 = 0;
    localparam int PORT_DISPLAY1 = 1;
    localparam int PORT_SWITCHES = 2;
    localparam int PORT_BUTTONS  = 3;

    // Debounce defaults used when the instantiating top does not override them.
    localparam int DEB_DIV_LOG2_DEFAULT = 16;
    localparam int DEB_SAMPLES_DEFAULT  = 4;

endpackage

// File: rtl/port_input_responder_debounce_bit.sv
// One board input: 2-flop synchroniser, sample history and debounced level.
// The level only moves when the whole history agrees, so any bounce that
// produces a mixed history leaves the previous level in place.
module debounce_bit
    import port_input_responder_pkg::*;
#(
    parameter int DEB_SAMPLES = DEB_SAMPLES_DEFAULT
) (
    input  logic mclk,
    input  logic rst_n,
    input  logic samp_stb,
    input  logic raw,
    output logic level
);

    logic                   sync1_q;
    logic                   sync2_q;
    logic [DEB_SAMPLES-1:0] hist_q;
    logic [DEB_SAMPLES-1:0] hist_d;
    logic                   level_q;
    logic                   level_d;

    // Next history and level, updated only on a sample strobe.
    always_comb begin
        hist_d  = hist_q;
        level_d = level_q;
        if (samp_stb) begin
            hist_d = {hist_q[DEB_SAMPLES-2:0], sync2_q};
            if (&hist_d) begin
                level_d = 1'b1;
            end else if (~|hist_d) begin
                level_d = 1'b0;
            end
        end
    end

    // Synchroniser, history and level registers.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            hist_q  <= hist_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/port_input_responder.sv
// Responder side of the CPU port bus for the board switches and buttons.
// Port BASE_ADDR returns the debounced switch levels; port BASE_ADDR+1 returns
// the sticky button-press events and debounced button levels, and clears the
// events once per CPU read (on the cpu_tick cycle).
module port_input_responder
    import port_input_responder_pkg::*;
#(
    parameter int WORD_SIZE    = port_input_responder_pkg::WORD_SIZE,
    parameter int BASE_ADDR    = PORT_SWITCHES,
    parameter int N_SW         = 8,
    parameter int N_BTN        = 4,
    parameter int DEB_DIV_LOG2 = DEB_DIV_LOG2_DEFAULT,
    parameter int DEB_SAMPLES  = DEB_SAMPLES_DEFAULT
) (
    input  logic                 mclk,
    input  logic                 rst_n,
    input  logic                 cpu_tick,
    input  logic [WORD_SIZE-1:0] portaddr,
    input  logic                 portget,
    output logic [WORD_SIZE-1:0] portout,
    output logic                 port_hit,
    input  logic [N_SW-1:0]      sw_in,
    input  logic [N_BTN-1:0]     btn_in,
    output logic [N_SW-1:0]      sw_level
);

    localparam int N_IN = N_SW + N_BTN;

    // The +1 wraps modulo 2^WORD_SIZE through the cast.
    localparam logic [WORD_SIZE-1:0] ADDR_SW  = WORD_SIZE'(BASE_ADDR);
    localparam logic [WORD_SIZE-1:0] ADDR_BTN = WORD_SIZE'(BASE_ADDR + 1);

    logic [DEB_DIV_LOG2-1:0] presc_q;
    logic [DEB_DIV_LOG2-1:0] presc_d;
    logic                    samp_stb;

    logic [N_IN-1:0]  raw_all;
    logic [N_IN-1:0]  level_all;
    logic [N_BTN-1:0] btn_level;

    logic [N_BTN-1:0] btn_prev_q;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] ev_q;
    logic [N_BTN-1:0] ev_d;

    logic hit0;
    logic hit1;
    logic ev_clr;

    // Free-running prescaler; strobe on the all-ones count, then wrap to zero.
    assign presc_d  = presc_q + DEB_DIV_LOG2'(1);
    assign samp_stb = &presc_q;

    // Prescaler register.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Switches occupy the low debounce slots, buttons the high ones.
    assign raw_all = {btn_in, sw_in};

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_deb
        debounce_bit #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .mclk    (mclk),
            .rst_n   (rst_n),
            .samp_stb(samp_stb),
            .raw     (raw_all[gi]),
            .level   (level_all[gi])
        );
    end

    assign sw_level  = level_all[N_SW-1:0];
    assign btn_level = level_all[N_SW +: N_BTN];

    // Decode is gated with rst_n so the bus sees no hit while in reset, even
    // if the CPU is already holding portget.
    assign hit0     = rst_n & portget & (portaddr == ADDR_SW);
    assign hit1     = rst_n & portget & (portaddr == ADDR_BTN);
    assign port_hit = hit0 | hit1;

    // One clear per CPU read: only the cpu_tick cycle of a button-port read.
    assign ev_clr   = cpu_tick & hit1;
    assign btn_rise = btn_level & ~btn_prev_q;

    // Event next state: the clear is applied first so a coincident rising edge
    // still leaves the bit set and no press is lost.
    always_comb begin
        ev_d = ev_q;
        if (ev_clr) begin
            ev_d = '0;
        end
        ev_d = ev_d | btn_rise;
    end

    // Previous button level and sticky event latches.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= '0;
            ev_q       <= '0;
        end else begin
            btn_prev_q <= btn_level;
            ev_q       <= ev_d;
        end
    end

    // Read mux; unused upper bits stay zero and no hit returns zero.
    always_comb begin
        portout = '0;
        if (hit0) begin
            portout[N_SW-1:0] = sw_level;
        end else if (hit1) begin
            portout[N_BTN-1:0]     = ev_q;
            portout[N_BTN +: N_BTN] = btn_level;
        end
    end

endmodule

// File: tb/tb_port_input_responder.sv
// Directed bench for port_input_responder with a fast debounce prescaler.
module tb_port_input_responder;

    logic        mclk;
    logic        rst_n;
    logic        cpu_tick;
    logic [15:0] portaddr;
    logic        portget;
    logic [15:0] portout;
    logic        port_hit;
    logic [7:0]  sw_in;
    logic [3:0]  btn_in;
    logic [7:0]  sw_level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [15:0] addr;
        logic        get;
        logic        tick;
        logic        exp_hit;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[10];

    port_input_responder #(
        .WORD_SIZE   (16),
        .BASE_ADDR   (2),
        .N_SW        (8),
        .N_BTN       (4),
        .DEB_DIV_LOG2(2),
        .DEB_SAMPLES (4)
    ) dut (
        .mclk    (mclk),
        .rst_n   (rst_n),
        .cpu_tick(cpu_tick),
        .portaddr(portaddr),
        .portget (portget),
        .portout (portout),
        .port_hit(port_hit),
        .sw_in   (sw_in),
        .btn_in  (btn_in),
        .sw_level(sw_level)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic step();
        @(posedge mclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [15:0] addr, input logic tick);
        portget  = 1'b1;
        portaddr = addr;
        cpu_tick = tick;
        #1;
    endtask

    initial begin
        int  lat;
        logic seen;
        logic found;

        vecs[0] = '{"dec_addr0",  16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[1] = '{"dec_addr1",  16'h0001, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[2] = '{"dec_addr4",  16'h0004, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[3] = '{"dec_addrFF", 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000};
        vecs[4] = '{"dec_noget",  16'h0003, 1'b0, 1'b1, 1'b0, 16'h0000};
        vecs[5] = '{"rd_sw",      16'h0002, 1'b1, 1'b1, 1'b1, 16'h00A5};
        vecs[6] = '{"rd_btn_nt1", 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0062};
        vecs[7] = '{"rd_btn_nt2", 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0062};
        vecs[8] = '{"rd_btn_clr", 16'h0003, 1'b1, 1'b1, 1'b1, 16'h0062};
        vecs[9] = '{"rd_btn_aft", 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0060};

        // 1. Reset and idle
        rst_n    = 1'b0;
        cpu_tick = 1'b0;
        portget  = 1'b1;
        portaddr = 16'h0002;
        sw_in    = 8'hA5;
        btn_in   = 4'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_portout", 32'(portout), 32'h0);
            chk("rst_hit", 32'(port_hit), 32'h0);
            chk("rst_sw_level", 32'(sw_level), 32'h0);
        end
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 18; i++) begin
            step();
            if (sw_level == 8'hA5 && lat == 0) lat = i;
        end
        chk("sw_latency", 32'(lat), 32'd16);
        chk("sw_level_a5", 32'(sw_level), 32'hA5);
        rd(16'h0002, 1'b0);
        chk("rd_sw_a5", 32'(portout), 32'h00A5);
        chk("rd_sw_hit", 32'(port_hit), 32'h1);

        // 2. Bounce rejection on button 0
        rd(16'h0003, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) btn_in[0] = ~btn_in[0];
            step();
            if (portout[0] || portout[4]) seen = 1'b1;
        end
        btn_in[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (portout[0] || portout[4]) seen = 1'b1;
        end
        chk("bounce_seen", 32'(seen), 32'h0);
        chk("bounce_final", 32'(portout), 32'h0000);

        // 3. Press button 2, read with clear, re-read
        btn_in[2] = 1'b1;
        for (int i = 0; i < 30; i++) step();
        rd(16'h0003, 1'b1);
        chk("press_rd1", 32'(portout), 32'h0044);
        chk("press_hit", 32'(port_hit), 32'h1);
        step();
        rd(16'h0003, 1'b0);
        chk("press_rd2", 32'(portout), 32'h0040);

        // 4. Read-clear coinciding with button 1's rising level
        btn_in[1] = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (portout[5]) found = 1'b1;
        end
        chk("coll_level_rose", 32'(found), 32'h1);
        cpu_tick = 1'b1;
        #1;
        chk("coll_rd1_bit1", 32'(portout[1]), 32'h0);
        step();
        cpu_tick = 1'b0;
        #1;
        chk("coll_rd2_bit1", 32'(portout[1]), 32'h1);

        // 5. Decode and non-clearing reads, table driven
        for (int i = 0; i < 10; i++) begin
            rd(vecs[i].addr, vecs[i].tick);
            portget = vecs[i].get;
            #1;
            chk({vecs[i].name, "_hit"}, 32'(port_hit), 32'(vecs[i].exp_hit));
            chk({vecs[i].name, "_out"}, 32'(portout), 32'(vecs[i].exp_out));
            step();
        end
        cpu_tick = 1'b0;

        // 6. Async reset while all four events are pending
        btn_in = 4'h0;
        for (int i = 0; i < 25; i++) step();
        btn_in = 4'hF;
        for (int i = 0; i < 25; i++) step();
        rd(16'h0003, 1'b0);
        chk("all_events", 32'(portout), 32'h00FF);
        cpu_tick = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("midrst_hit", 32'(port_hit), 32'h0);
        chk("midrst_out", 32'(portout), 32'h0);
        btn_in = 4'h0;
        step();
        rst_n    = 1'b1;
        cpu_tick = 1'b0;
        for (int i = 0; i < 25; i++) step();
        rd(16'h0003, 1'b0);
        chk("post_rst_events", 32'(portout), 32'h0000);
        chk("post_rst_sw", 32'(sw_level), 32'hA5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
